// File: rtl/dot_accumulator.sv
// Sums DIM signed products into one saturated matrix element, walking row/col
// indices across a DIM x DIM result and presenting each element on ready/valid.
module dot_accumulator #(
  parameter int DATA_W = 8,
  parameter int DIM    = 5,
  parameter int ACC_W  = 12,
  parameter int IDX_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] prod,
  input  logic                     prod_ovf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_ovf,
  output logic [IDX_W-1:0]         out_row,
  output logic [IDX_W-1:0]         out_col,
  output logic                     busy,
  output logic                     done
);

  // state  | meaning
  // IDLE   | waiting for start; accumulator and indices cleared
  // ACCUM  | accepting DIM products for the current element
  // OUTPUT | element presented, waiting for out_ready
  // DONE   | one-cycle done pulse after the last element
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUTPUT, S_DONE} state_t;

  localparam int CNT_W = $clog2(DIM + 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  state_t                     state_q, state_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       sticky_q, sticky_d;
  logic [IDX_W-1:0]           row_q, row_d;
  logic [IDX_W-1:0]           col_q, col_d;
  logic signed [DATA_W-1:0]   data_q, data_d;
  logic                       ovf_q, ovf_d;

  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    sum;
  logic                       sat_hi;
  logic                       sat_lo;

  assign prod_ext = ACC_W'(prod);
  assign sum      = acc_q + prod_ext;
  assign sat_hi   = (sum > SAT_MAX);
  assign sat_lo   = (sum < SAT_MIN);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    row_d    = row_q;
    col_d    = col_q;
    data_d   = data_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        acc_d    = '0;
        cnt_d    = '0;
        sticky_d = 1'b0;
        row_d    = '0;
        col_d    = '0;
        if (start) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (in_valid) begin
          acc_d    = sum;
          sticky_d = sticky_q | prod_ovf;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DIM - 1)) begin
            if (sat_hi)      data_d = SAT_MAX[DATA_W-1:0];
            else if (sat_lo) data_d = SAT_MIN[DATA_W-1:0];
            else             data_d = sum[DATA_W-1:0];
            ovf_d   = sticky_q | prod_ovf | sat_hi | sat_lo;
            state_d = S_OUTPUT;
          end
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          acc_d    = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
          if (row_q == IDX_W'(DIM - 1) && col_q == IDX_W'(DIM - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ACCUM;
            if (col_q == IDX_W'(DIM - 1)) begin
              col_d = '0;
              row_d = row_q + IDX_W'(1);
            end else begin
              col_d = col_q + IDX_W'(1);
            end
          end
        end
      end
      S_DONE: begin
        row_d   = '0;
        col_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      row_q    <= row_d;
      col_q    <= col_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

  // Handshake outputs decode the state register only, so no input reaches them combinationally.
  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_OUTPUT);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign out_data  = data_q;
  assign out_ovf   = ovf_q;
  assign out_row   = row_q;
  assign out_col   = col_q;

endmodule
